mdu_sequencer: RTL
==================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 64, operand/result width.
REQ-002 Parameter CNT_W, default 7, iteration counter width; SHALL be at least clog2(DATA_WIDTH)+1.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_arst  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  M-extension instruction present in execute stage.
REQ-006 i_op  input  3  func3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 i_src1  input  DATA_WIDTH  forwarded rs1 operand (multiplicand/dividend).
REQ-008 i_src2  input  DATA_WIDTH  forwarded rs2 operand (multiplier/divisor).
REQ-009 i_flush  input  1  branch mispredict kill of the execute-stage instruction.
REQ-010 i_stall_mem  input  1  memory-stage stall; execute pipeline register holds.
REQ-011 o_stall_exec  output  1  freeze fetch/decode/execute, execute register inserts no advance.
REQ-012 o_done  output  1  o_result valid for the execute-stage instruction this cycle.
REQ-013 o_result  output  DATA_WIDTH  operation result, feeds the execute pipeline register via the result mux.
REQ-014 o_busy  output  1  state is not IDLE.

Function
REQ-015 FSM states IDLE, CALC, DONE (EARLY state only with REQ-033).
REQ-016 IDLE: i_start=1 and i_flush=0 -> latch op, operand magnitudes, result signs; counter=DATA_WIDTH; go CALC.
REQ-017 CALC: one radix-2 iteration per cycle (shift-add multiply over 2*DATA_WIDTH accumulator, restoring divide); counter decrements; counter reaching 0 -> DONE.
REQ-018 Latency: i_start sampled in cycle 0 -> CALC cycles 1..DATA_WIDTH -> o_done=1 in cycle DATA_WIDTH+1 (65 at default).
REQ-019 o_stall_exec = (IDLE & i_start & ~i_flush) | CALC; deasserted in DONE so the result is captured.
REQ-020 DONE: o_done=1; i_stall_mem=0 -> IDLE next cycle; i_stall_mem=1 -> remain DONE, o_result stable.
REQ-021 Signed ops operate on magnitudes; final negation applied when leaving CALC: quotient sign = s1^s2, remainder sign = s1, product sign = s1^s2 (MULHSU: src2 unsigned).
REQ-022 MUL returns product[DATA_WIDTH-1:0]; MULH/MULHSU/MULHU return product[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-023 Divide by zero: DIV/DIVU quotient all ones; REM/REMU result = i_src1.
REQ-024 Signed overflow (src1 = most-negative, src2 = -1): DIV result = src1, REM result = 0.
REQ-025 i_flush=1 in any state -> IDLE next cycle, o_done=0 that cycle and next; flush has priority over start and over i_stall_mem.
REQ-026 i_start deassertion during CALC is ignored; operands are latched, not re-sampled.
REQ-027 DONE->IDLE followed by i_start in the following cycle starts a new operation (back-to-back ops, no extra bubble beyond IDLE cycle).
REQ-028 o_result outside DONE holds last computed value; consumers qualify with o_done.

Reset
REQ-029 i_arst=1 -> state IDLE, counter 0, accumulators 0, o_result 0, o_done 0, o_stall_exec 0, o_busy 0, immediately and asynchronously.
REQ-030 Reset mid-CALC or mid-DONE aborts the operation; no o_done produced.
REQ-031 First operation SHALL be accepted in the first cycle after i_arst deasserts.

Configuration
REQ-032 Macro MDU_EARLY_OUT_EN selects early termination.
REQ-033 Defined: divide-by-zero, signed overflow, and either multiply operand = 0 bypass CALC; IDLE -> EARLY (stall 1) -> DONE; o_done in cycle 2.
REQ-034 Undefined: all operations take full DATA_WIDTH iterations; results identical to REQ-023/REQ-024.

Verification
REQ-035 MUL src1=7, src2=-3 -> o_done at cycle 65, o_result=0xFFFF_FFFF_FFFF_FFEB, o_stall_exec high cycles 0..64.
REQ-036 MULHU src1=src2=0xFFFF_FFFF_FFFF_FFFF -> o_result=0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> 0.
REQ-037 DIV src1=-20, src2=6 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD); REM same -> -2.
REQ-038 DIVU src2=0, src1=0x1234 -> all ones; REM src2=0 -> 0x1234; with MDU_EARLY_OUT_EN o_done at cycle 2, else cycle 65.
REQ-039 i_flush at cycle 30 of CALC -> IDLE at cycle 31, no o_done; i_stall_mem high 3 cycles in DONE -> o_done held 4 cycles, o_result stable.
REQ-040 i_arst pulsed at cycle 10 of DIV -> all outputs 0 at once; new MUL 2*3 after release -> 6 at cycle 65.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV64M multiply/divide unit for an in-order pipeline.
// Shift-add multiply over a 2*DATA_WIDTH accumulator and restoring divide,
// one radix-2 step per cycle, holding the execute stage via o_stall_exec.
//
// Optional feature macro: MDU_EARLY_OUT_EN
//   When defined, divide-by-zero, signed divide overflow and multiply with a
//   zero operand skip the iteration loop through a one-cycle EARLY state.
//   When undefined, every operation runs the full DATA_WIDTH iterations.
module mdu_sequencer #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_W      = 7
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_src1,
    input  logic [DATA_WIDTH-1:0] i_src2,
    input  logic                  i_flush,
    input  logic                  i_stall_mem,
    output logic                  o_stall_exec,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_busy
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [DW-1:0] D_ZERO = {DW{1'b0}};
    localparam logic [DW-1:0] D_ONES = {DW{1'b1}};
    localparam logic [DW-1:0] D_MIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [PW-1:0] P_ZERO = {PW{1'b0}};

`ifdef MDU_EARLY_OUT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DONE  = 2'd2,
        ST_EARLY = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;
`endif

    // Final result formation: sign fix-up of the magnitude result plus the
    // architecturally defined divide-by-zero and overflow values.
    function automatic logic [DW-1:0] final_result(
        input logic [2:0]    op,
        input logic [PW-1:0] acc,
        input logic          neg,
        input logic          div0,
        input logic          ovf,
        input logic [DW-1:0] src1
    );
        logic [PW-1:0] prod;
        logic [DW-1:0] quo;
        logic [DW-1:0] rem;
        logic [DW-1:0] res;
        prod = neg ? (P_ZERO - acc) : acc;
        quo  = neg ? (D_ZERO - acc[DW-1:0]) : acc[DW-1:0];
        rem  = neg ? (D_ZERO - acc[PW-1:DW]) : acc[PW-1:DW];
        case (op)
            OP_MUL:                      res = prod[DW-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod[PW-1:DW];
            OP_DIV, OP_DIVU: begin
                if (div0) begin
                    res = D_ONES;
                end else if (ovf) begin
                    res = src1;
                end else begin
                    res = quo;
                end
            end
            OP_REM, OP_REMU: begin
                if (div0) begin
                    res = src1;
                end else if (ovf) begin
                    res = D_ZERO;
                end else begin
                    res = rem;
                end
            end
            default:                     res = D_ZERO;
        endcase
        return res;
    endfunction

    // State and datapath registers
    state_e          state_q,  state_d;
    logic [2:0]      op_q,     op_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [PW-1:0]   acc_q,    acc_d;
    logic [DW-1:0]   opnd_q,   opnd_d;
    logic [DW-1:0]   src1_q,   src1_d;
    logic            neg_q,    neg_d;
    logic            div0_q,   div0_d;
    logic            ovf_q,    ovf_d;
    logic [DW-1:0]   result_q, result_d;

    // Incoming-operation decode
    logic            in_is_div_s;
    logic            in_s1_signed_s;
    logic            in_s2_signed_s;
    logic            in_s1_s;
    logic            in_s2_s;
    logic [DW-1:0]   in_mag1_s;
    logic [DW-1:0]   in_mag2_s;
    logic            in_div0_s;
    logic            in_ovf_s;
    logic            in_neg_s;

    // One-iteration datapath
    logic [DW:0]     mul_sum_s;
    logic [PW-1:0]   mul_next_s;
    logic [DW:0]     div_trial_s;
    logic            div_qbit_s;
    logic [PW-1:0]   div_next_s;

    // Decode operand signs, magnitudes and special cases of the incoming op
    always_comb begin
        in_is_div_s    = i_op[2];
        in_s1_signed_s = (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                         (i_op == OP_DIV)  || (i_op == OP_REM);
        in_s2_signed_s = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
        in_s1_s        = in_s1_signed_s & i_src1[DW-1];
        in_s2_s        = in_s2_signed_s & i_src2[DW-1];
        in_mag1_s      = in_s1_s ? (D_ZERO - i_src1) : i_src1;
        in_mag2_s      = in_s2_s ? (D_ZERO - i_src2) : i_src2;
        in_div0_s      = in_is_div_s && (i_src2 == D_ZERO);
        in_ovf_s       = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                         (i_src1 == D_MIN) && (i_src2 == D_ONES);
        // Remainder takes the dividend sign; product and quotient take s1^s2
        in_neg_s       = (i_op == OP_REM) ? in_s1_s : (in_s1_s ^ in_s2_s);
    end

`ifdef MDU_EARLY_OUT_EN
    logic in_early_s;

    // Operations whose result is known without iterating
    always_comb begin
        in_early_s = in_div0_s || in_ovf_s ||
                     (!in_is_div_s && ((i_src1 == D_ZERO) || (i_src2 == D_ZERO)));
    end
`endif

    // Single radix-2 step: shift-add multiply and restoring divide
    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half the
        // partial product; the adder carry shifts into the top bit.
        mul_sum_s   = {1'b0, acc_q[PW-1:DW]} +
                      (acc_q[0] ? {1'b0, opnd_q} : {(DW+1){1'b0}});
        mul_next_s  = {mul_sum_s, acc_q[DW-1:1]};
        // Divide: high half is the partial remainder, low half shifts the
        // dividend out and the quotient bits in.
        div_trial_s = acc_q[PW-1:DW-1] - {1'b0, opnd_q};
        div_qbit_s  = ~div_trial_s[DW];
        div_next_s  = {(div_qbit_s ? div_trial_s[DW-1:0] : acc_q[PW-2:DW-1]),
                       acc_q[DW-2:0], div_qbit_s};
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        src1_d   = src1_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;

        if (i_flush) begin
            // Killed instruction: drop whatever is in flight
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        op_d   = i_op;
                        cnt_d  = CNT_INIT;
                        opnd_d = in_is_div_s ? in_mag2_s : in_mag1_s;
                        acc_d  = {D_ZERO, (in_is_div_s ? in_mag1_s : in_mag2_s)};
                        src1_d = i_src1;
                        neg_d  = in_neg_s;
                        div0_d = in_div0_s;
                        ovf_d  = in_ovf_s;
`ifdef MDU_EARLY_OUT_EN
                        if (in_early_s) begin
                            state_d = ST_EARLY;
                        end else begin
                            state_d = ST_CALC;
                        end
`else
                        state_d = ST_CALC;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_d = op_q[2] ? div_next_s : mul_next_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d  = ST_DONE;
                        result_d = final_result(op_q, acc_d, neg_q, div0_q, ovf_q, src1_q);
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (i_stall_mem) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef MDU_EARLY_OUT_EN
                ST_EARLY: begin
                    // Zero product, or a div0/overflow value picked by the flags
                    result_d = final_result(op_q, P_ZERO, neg_q, div0_q, ovf_q, src1_q);
                    state_d  = ST_DONE;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'd0;
            cnt_q    <= CNT_ZERO;
            acc_q    <= P_ZERO;
            opnd_q   <= D_ZERO;
            src1_q   <= D_ZERO;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= D_ZERO;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            src1_q   <= src1_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    // Pipeline handshake outputs; the IDLE term lets the stall assert in the
    // same cycle the instruction is accepted.
    always_comb begin
        o_stall_exec = ((state_q == ST_IDLE) && i_start && !i_flush) ||
`ifdef MDU_EARLY_OUT_EN
                       (state_q == ST_EARLY) ||
`endif
                       (state_q == ST_CALC);
        o_done       = (state_q == ST_DONE) && !i_flush;
        o_busy       = (state_q != ST_IDLE);
        o_result     = result_q;
    end

endmodule
